// File: rtl/seg_scan_if.sv
// Load/ack and display-drive bundle for the seven-segment scan controller.
// The host side drives load/data; the controller drives the panel pins.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     an;
  logic                  dp;
  logic                  ack;

  modport master (
    output load, data, dp_in, blank_lz,
    input  nib, an, dp, ack
  );

  modport slave (
    input  load, data, dp_in, blank_lz,
    output nib, an, dp, ack
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Frame-boundary load/ack, guard blanking, leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CLAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] DLAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CGRD  = CW'(GUARD);

  typedef enum logic {BLANK, SHOW} phase_e;

  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] sd, sd_n;
  logic [DIGITS-1:0]   sp, sp_n;
  logic                wrap, cap;
  phase_e              ph_n;
  logic [DIGITS-1:0]   sup;
  logic                hi_zero;
  logic [3:0]          nib_n;
  logic [DIGITS-1:0]   an_n;
  logic                dp_n;

  always_comb begin
    wrap  = (cnt == CLAST);
    cnt_n = wrap ? '0 : cnt + 1'b1;
    idx_n = idx;
    if (wrap)
      idx_n = (idx == DLAST) ? '0 : idx + 1'b1;
    cap  = wrap && (idx == DLAST) && bus.load;
    sd_n = cap ? bus.data  : sd;
    sp_n = cap ? bus.dp_in : sp;
    ph_n = (cnt_n >= CGRD) ? SHOW : BLANK;
  end

  // A digit is suppressed only if it and everything above it is zero.
  always_comb begin
    hi_zero = 1'b1;
    sup     = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      hi_zero = hi_zero && (sd_n[4*k +: 4] == 4'd0);
      sup[k]  = bus.blank_lz && hi_zero && !sp_n[k];
    end
  end

  always_comb begin
    nib_n = sd_n[{idx_n, 2'b00} +: 4];
    an_n  = '1;
    dp_n  = 1'b0;
    unique case (ph_n)
      SHOW: begin
        dp_n = sp_n[idx_n];
        if (!sup[idx_n])
          an_n[idx_n] = 1'b0;
      end
      BLANK: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      sd      <= '0;
      sp      <= '0;
      bus.nib <= '0;
      bus.an  <= '1;
      bus.dp  <= 1'b0;
      bus.ack <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      sd      <= sd_n;
      sp      <= sp_n;
      bus.nib <= nib_n;
      bus.an  <= an_n;
      bus.dp  <= dp_n;
      bus.ack <= cap;
    end
  end
endmodule
